apb_spi_xip_bridge: RTL and testbench

//  APB slave that fronts an external Wishbone SPI master core (RX/TX 0x00-0x0C, CTRL 0x10, DIVIDER 0x14, SS 0x18).

---
 rtl/apb_spi_xip_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_apb_spi_xip_bridge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_spi_xip_bridge.sv
// APB slave in front of a Wishbone SPI master core: register passthrough plus
// an autonomous execute-in-place read sequence for the flash window.
module apb_spi_xip_bridge #(
  parameter logic [31:0] FLASH_BASE  = 32'h3000_0000,
  parameter logic [31:0] FLASH_END   = 32'h3FFF_FFFF,
  parameter logic [31:0] REG_BASE    = 32'h1000_1000,
  parameter logic [31:0] REG_END     = 32'h1000_1FFF,
  parameter int          XIP_BYTES   = 4,
  parameter logic [7:0]  READ_OPCODE = 8'h03,
  parameter logic [15:0] DIVIDER     = 16'd1,
  parameter int          SS_INDEX    = 0,
  parameter bit          SWAP_BYTES  = 1'b1,
  parameter int          TIMEOUT     = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        xip_busy
);

  typedef enum logic [3:0] {
    IDLE, WR_TX1, WR_DIV, WR_SS, WR_CTRL, POLL, RD_RX0, CLR_SS, RESP
  } state_t;

  localparam logic [6:0]  CHAR_LEN  = 7'(32 + 8 * XIP_BYTES);
  // CTRL: ASS(13), TX_NEG(10), GO(8), CHAR_LEN(6:0)
  localparam logic [31:0] CTRL_WORD = {18'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, CHAR_LEN};
  localparam logic [31:0] SS_WORD   = 32'd1 << SS_INDEX;
  localparam logic [31:0] POLL_LAST = 32'(TIMEOUT - 1);

  state_t      state, state_next, ok_next;
  logic        gap;
  logic [23:0] addr_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        lost;
  logic [31:0] poll_cnt;

  logic        access, in_flash, in_reg;
  logic        seq_cyc, seq_we, hs, poll_step, timeout_hit, capture;
  logic [4:0]  seq_adr;
  logic [31:0] seq_dat;
  logic [31:0] rx_data;

  assign access   = psel & penable;
  assign in_flash = (paddr >= FLASH_BASE) && (paddr <= FLASH_END);
  assign in_reg   = (paddr >= REG_BASE) && (paddr <= REG_END);
  assign xip_busy = (state != IDLE);

  // RX0 holds the received bytes with the first one most significant.
  always_comb begin
    rx_data = 32'h0;
    for (int i = 0; i < XIP_BYTES; i++) begin
      if (SWAP_BYTES)
        rx_data[8*i +: 8] = wb_dat_i[8*(XIP_BYTES-1-i) +: 8];
      else
        rx_data[8*i +: 8] = wb_dat_i[8*i +: 8];
    end
  end

  always_comb begin
    state_next  = state;
    ok_next     = state;
    seq_cyc     = 1'b0;
    seq_we      = 1'b0;
    seq_adr     = 5'h00;
    seq_dat     = 32'h0;
    hs          = 1'b0;
    poll_step   = 1'b0;
    timeout_hit = 1'b0;
    capture     = 1'b0;
    pready      = 1'b0;
    prdata      = 32'h0;
    pslverr     = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_adr_o    = 5'h00;
    wb_dat_o    = 32'h0;
    wb_sel_o    = 4'h0;

    case (state)
      IDLE: begin
        if (access) begin
          if (in_reg) begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_we_o  = pwrite;
            wb_adr_o = paddr[4:0];
            wb_dat_o = pwdata;
            wb_sel_o = pstrb;
            pready   = wb_ack_i;
            prdata   = wb_dat_i;
            pslverr  = wb_err_i;
          end else if (in_flash && !pwrite) begin
            state_next = WR_TX1;
          end else begin
            pready  = 1'b1;
            pslverr = 1'b1;
          end
        end
      end
      WR_TX1: begin
        seq_cyc = !gap; seq_we = 1'b1; seq_adr = 5'h04;
        seq_dat = {READ_OPCODE, addr_q};
        ok_next = WR_DIV;
      end
      WR_DIV: begin
        seq_cyc = !gap; seq_we = 1'b1; seq_adr = 5'h14;
        seq_dat = {16'h0, DIVIDER};
        ok_next = WR_SS;
      end
      WR_SS: begin
        seq_cyc = !gap; seq_we = 1'b1; seq_adr = 5'h18;
        seq_dat = SS_WORD;
        ok_next = WR_CTRL;
      end
      WR_CTRL: begin
        seq_cyc = !gap; seq_we = 1'b1; seq_adr = 5'h10;
        seq_dat = CTRL_WORD;
        ok_next = POLL;
      end
      POLL: begin
        seq_cyc = !gap; seq_adr = 5'h10;
        if (!wb_dat_i[8])
          ok_next = RD_RX0;
        else if (poll_cnt == POLL_LAST)
          ok_next = CLR_SS;
        else
          ok_next = POLL;
      end
      RD_RX0: begin
        seq_cyc = !gap; seq_adr = 5'h00;
        ok_next = CLR_SS;
      end
      CLR_SS: begin
        seq_cyc = !gap; seq_we = 1'b1; seq_adr = 5'h18;
        ok_next = RESP;
      end
      RESP: begin
        pready     = !lost;
        pslverr    = err_q & !lost;
        prdata     = (err_q || lost) ? 32'h0 : rdata_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    hs          = seq_cyc & (wb_ack_i | wb_err_i);
    poll_step   = (state == POLL) && hs && !wb_err_i && wb_dat_i[8];
    timeout_hit = poll_step && (poll_cnt == POLL_LAST);
    capture     = (state == RD_RX0) && hs && !wb_err_i;

    // A bus error anywhere still releases slave select before responding.
    if (hs) begin
      if (wb_err_i)
        state_next = (state == CLR_SS) ? RESP : CLR_SS;
      else
        state_next = ok_next;
    end

    if (state != IDLE) begin
      wb_cyc_o = seq_cyc;
      wb_stb_o = seq_cyc;
      wb_we_o  = seq_cyc & seq_we;
      wb_adr_o = seq_adr;
      wb_dat_o = seq_dat;
      wb_sel_o = {4{seq_cyc}};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gap      <= 1'b0;
      addr_q   <= 24'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      lost     <= 1'b0;
      poll_cnt <= 32'h0;
    end else begin
      state <= state_next;
      gap   <= hs;
      if (state == IDLE) begin
        if (state_next == WR_TX1) begin
          addr_q   <= paddr[23:0];
          rdata_q  <= 32'h0;
          err_q    <= 1'b0;
          lost     <= 1'b0;
          poll_cnt <= 32'h0;
        end
      end else begin
        if (!access)
          lost <= 1'b1;
        if ((hs && wb_err_i) || timeout_hit)
          err_q <= 1'b1;
        if (poll_step)
          poll_cnt <= poll_cnt + 32'd1;
        if (capture)
          rdata_q <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_apb_spi_xip_bridge.sv
// Directed bench for apb_spi_xip_bridge: two parameterisations share one
// behavioural Wishbone SPI core model, selected by use_b.
`timescale 1ns/1ps
module tb_apb_spi_xip_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] paddr = 32'h0, pwdata = 32'h0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0]  pstrb = 4'h0;
  logic        use_b = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  logic        psel_a, psel_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b, busy_a, busy_b;
  logic [31:0] prdata_a, prdata_b, wb_dat_a, wb_dat_b;
  logic [4:0]  wb_adr_a, wb_adr_b;
  logic [3:0]  wb_sel_a, wb_sel_b;
  logic        wb_we_a, wb_we_b, wb_stb_a, wb_stb_b, wb_cyc_a, wb_cyc_b;

  logic        m_ack = 1'b0, m_err = 1'b0;
  logic        m_cyc, m_stb, m_we;
  logic [4:0]  m_adr;
  logic [31:0] m_dat, m_rdat;
  logic        pready_m, pslverr_m;
  logic [31:0] prdata_m;

  assign psel_a    = psel & ~use_b;
  assign psel_b    = psel & use_b;
  assign m_cyc     = use_b ? wb_cyc_b : wb_cyc_a;
  assign m_stb     = use_b ? wb_stb_b : wb_stb_a;
  assign m_we      = use_b ? wb_we_b  : wb_we_a;
  assign m_adr     = use_b ? wb_adr_b : wb_adr_a;
  assign m_dat     = use_b ? wb_dat_b : wb_dat_a;
  assign pready_m  = use_b ? pready_b  : pready_a;
  assign pslverr_m = use_b ? pslverr_b : pslverr_a;
  assign prdata_m  = use_b ? prdata_b  : prdata_a;

  apb_spi_xip_bridge #(.TIMEOUT(16)) dut_a (
    .clock(clock), .reset(reset), .paddr(paddr), .psel(psel_a), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_a),
    .prdata(prdata_a), .pslverr(pslverr_a), .wb_adr_o(wb_adr_a), .wb_dat_o(wb_dat_a),
    .wb_dat_i(m_rdat), .wb_sel_o(wb_sel_a), .wb_we_o(wb_we_a), .wb_stb_o(wb_stb_a),
    .wb_cyc_o(wb_cyc_a), .wb_ack_i(m_ack & ~use_b), .wb_err_i(m_err & ~use_b),
    .xip_busy(busy_a));

  apb_spi_xip_bridge #(.XIP_BYTES(2), .SWAP_BYTES(1'b0), .TIMEOUT(16)) dut_b (
    .clock(clock), .reset(reset), .paddr(paddr), .psel(psel_b), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_b),
    .prdata(prdata_b), .pslverr(pslverr_b), .wb_adr_o(wb_adr_b), .wb_dat_o(wb_dat_b),
    .wb_dat_i(m_rdat), .wb_sel_o(wb_sel_b), .wb_we_o(wb_we_b), .wb_stb_o(wb_stb_b),
    .wb_cyc_o(wb_cyc_b), .wb_ack_i(m_ack & use_b), .wb_err_i(m_err & use_b),
    .xip_busy(busy_b));

  // SPI core model: GO clears on the third status poll unless stuck is set.
  logic        stuck = 1'b0;
  logic        err_en = 1'b0;
  logic [4:0]  err_adr = 5'h00;
  logic [31:0] model_rx = 32'h0;
  logic [31:0] ctrl_r, rx0_r, div_r, ss_r;
  int          go_cnt;

  assign m_rdat = (m_adr == 5'h00) ? rx0_r :
                  (m_adr == 5'h10) ? ctrl_r :
                  (m_adr == 5'h14) ? div_r :
                  (m_adr == 5'h18) ? ss_r : 32'h0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ack <= 1'b0; m_err <= 1'b0;
      ctrl_r <= 32'h0; rx0_r <= 32'h0; div_r <= 32'h0; ss_r <= 32'h0;
      go_cnt <= 0;
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      if (m_cyc && m_stb && !m_ack && !m_err) begin
        if (err_en && m_adr == err_adr) m_err <= 1'b1;
        else m_ack <= 1'b1;
        if (m_we) begin
          case (m_adr)
            5'h10: begin ctrl_r <= m_dat; if (m_dat[8]) go_cnt <= 3; end
            5'h14: div_r <= m_dat;
            5'h18: ss_r <= m_dat;
            default: ;
          endcase
        end else if (m_adr == 5'h10 && go_cnt != 0 && !stuck) begin
          if (go_cnt == 1) begin ctrl_r[8] <= 1'b0; rx0_r <= model_rx; end
          go_cnt <= go_cnt - 1;
        end
      end
    end
  end

  logic [4:0]  log_adr [0:63];
  logic [31:0] log_dat [0:63];
  logic [3:0]  log_sel [0:63];
  int log_n = 0, poll_n = 0, cyc_cnt = 0;

  always @(posedge clock) begin
    if (wb_cyc_a || wb_cyc_b) cyc_cnt <= cyc_cnt + 1;
    if (!reset && m_cyc && m_stb && !m_ack && !m_err) begin
      if (m_we && log_n < 64) begin
        log_adr[log_n] <= m_adr; log_dat[log_n] <= m_dat; log_sel[log_n] <= {m_stb, m_stb, m_stb, m_stb} & (use_b ? wb_sel_b : wb_sel_a);
        log_n <= log_n + 1;
      end
      if (!m_we && m_adr == 5'h10) poll_n <= poll_n + 1;
    end
  end

  task automatic apb_xfer(input logic b, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err,
                          output int waits, output logic timed_out);
    rdata = 32'h0; err = 1'b0; waits = 0; timed_out = 1'b1;
    @(posedge clock); #1;
    use_b = b; paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb;
    psel = 1'b1; penable = 1'b0;
    @(posedge clock); #1;
    penable = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      waits++;
      if (pready_m) begin
        rdata = prdata_m; err = pslverr_m; timed_out = 1'b0;
        break;
      end
    end
    @(posedge clock); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er, to;
  int          wt, base, pb, cb;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if ({pready_a, pslverr_a, wb_cyc_a, wb_stb_a, wb_we_a, busy_a, prdata_a} !== 38'h0) begin n_fail++; $display("[TB] FAIL reset_a: got %h expected 0", {pready_a, pslverr_a, wb_cyc_a, wb_stb_a, wb_we_a, busy_a, prdata_a}); end
    n_checks++; if ({pready_b, pslverr_b, wb_cyc_b, wb_stb_b, wb_we_b, busy_b, prdata_b} !== 38'h0) begin n_fail++; $display("[TB] FAIL reset_b: got %h expected 0", {pready_b, pslverr_b, wb_cyc_b, wb_stb_b, wb_we_b, busy_b, prdata_b}); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reg_access();
    base = log_n;
    apb_xfer(1'b0, 32'h1000_1014, 1'b1, 32'h5, 4'hF, rd, er, wt, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL reg_wr_timeout: got %b expected 0", to); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("[TB] FAIL reg_wr_err: got %b expected 0", er); end
    n_checks++; if (log_n - base !== 1) begin n_fail++; $display("[TB] FAIL reg_wr_count: got %0d expected 1", log_n - base); end
    n_checks++; if ({log_adr[base], log_dat[base], log_sel[base]} !== {5'h14, 32'h5, 4'hF}) begin n_fail++; $display("[TB] FAIL reg_wr_beat: got %h %h %h expected 14 00000005 f", log_adr[base], log_dat[base], log_sel[base]); end
    apb_xfer(1'b0, 32'h1000_1014, 1'b0, 32'h0, 4'hF, rd, er, wt, to);
    n_checks++; if ({to, er, rd} !== {2'b00, 32'h5}) begin n_fail++; $display("[TB] FAIL reg_rd: got to=%b err=%b data=%h expected 0 0 00000005", to, er, rd); end
  endtask

  task automatic test_flash_read();
    model_rx = 32'h1122_3344;
    base = log_n; pb = poll_n;
    apb_xfer(1'b0, 32'h3000_0100, 1'b0, 32'h0, 4'hF, rd, er, wt, to);
    n_checks++; if ({to, er} !== 2'b00) begin n_fail++; $display("[TB] FAIL xip_status: got to=%b err=%b expected 0 0", to, er); end
    n_checks++; if (rd !== 32'h4433_2211) begin n_fail++; $display("[TB] FAIL xip_data: got %h expected 44332211", rd); end
    n_checks++; if (log_n - base !== 5) begin n_fail++; $display("[TB] FAIL xip_wr_count: got %0d expected 5", log_n - base); end
    n_checks++; if ({log_adr[base], log_dat[base]} !== {5'h04, 32'h0300_0100}) begin n_fail++; $display("[TB] FAIL xip_tx1: got %h %h expected 04 03000100", log_adr[base], log_dat[base]); end
    n_checks++; if ({log_adr[base+1], log_dat[base+1]} !== {5'h14, 32'h1}) begin n_fail++; $display("[TB] FAIL xip_div: got %h %h expected 14 00000001", log_adr[base+1], log_dat[base+1]); end
    n_checks++; if ({log_adr[base+2], log_dat[base+2]} !== {5'h18, 32'h1}) begin n_fail++; $display("[TB] FAIL xip_ss: got %h %h expected 18 00000001", log_adr[base+2], log_dat[base+2]); end
    n_checks++; if ({log_adr[base+3], log_dat[base+3]} !== {5'h10, 32'h2540}) begin n_fail++; $display("[TB] FAIL xip_ctrl: got %h %h expected 10 00002540", log_adr[base+3], log_dat[base+3]); end
    n_checks++; if ({log_adr[base+4], log_dat[base+4]} !== {5'h18, 32'h0}) begin n_fail++; $display("[TB] FAIL xip_clr_ss: got %h %h expected 18 00000000", log_adr[base+4], log_dat[base+4]); end
    n_checks++; if (poll_n - pb !== 3) begin n_fail++; $display("[TB] FAIL xip_polls: got %0d expected 3", poll_n - pb); end
    n_checks++; if (wt < 14) begin n_fail++; $display("[TB] FAIL xip_latency: got %0d cycles expected at least 14", wt); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("[TB] FAIL xip_busy_after: got %b expected 0", busy_a); end
  endtask

  task automatic test_short_read();
    model_rx = 32'h1234_ABCD;
    base = log_n;
    apb_xfer(1'b1, 32'h30AB_CDEF, 1'b0, 32'h0, 4'hF, rd, er, wt, to);
    n_checks++; if ({to, er} !== 2'b00) begin n_fail++; $display("[TB] FAIL short_status: got to=%b err=%b expected 0 0", to, er); end
    n_checks++; if (rd !== 32'h0000_ABCD) begin n_fail++; $display("[TB] FAIL short_data: got %h expected 0000abcd", rd); end
    n_checks++; if (log_dat[base] !== 32'h03AB_CDEF) begin n_fail++; $display("[TB] FAIL short_tx1: got %h expected 03abcdef", log_dat[base]); end
    n_checks++; if (log_dat[base+3] !== 32'h2530) begin n_fail++; $display("[TB] FAIL short_ctrl: got %h expected 00002530", log_dat[base+3]); end
  endtask

  task automatic test_timeout();
    stuck = 1'b1;
    base = log_n; pb = poll_n;
    apb_xfer(1'b0, 32'h3000_0040, 1'b0, 32'h0, 4'hF, rd, er, wt, to);
    stuck = 1'b0;
    n_checks++; if ({to, er, rd} !== {2'b01, 32'h0}) begin n_fail++; $display("[TB] FAIL timeout_resp: got to=%b err=%b data=%h expected 0 1 00000000", to, er, rd); end
    n_checks++; if (poll_n - pb !== 16) begin n_fail++; $display("[TB] FAIL timeout_polls: got %0d expected 16", poll_n - pb); end
    n_checks++; if ({log_adr[base+4], log_dat[base+4]} !== {5'h18, 32'h0}) begin n_fail++; $display("[TB] FAIL timeout_clr_ss: got %h %h expected 18 00000000", log_adr[base+4], log_dat[base+4]); end
  endtask

  task automatic test_wb_error();
    err_en = 1'b1; err_adr = 5'h14;
    base = log_n;
    apb_xfer(1'b0, 32'h3000_0000, 1'b0, 32'h0, 4'hF, rd, er, wt, to);
    err_en = 1'b0;
    n_checks++; if ({to, er, rd} !== {2'b01, 32'h0}) begin n_fail++; $display("[TB] FAIL wberr_resp: got to=%b err=%b data=%h expected 0 1 00000000", to, er, rd); end
    n_checks++; if (log_n - base !== 3) begin n_fail++; $display("[TB] FAIL wberr_count: got %0d expected 3", log_n - base); end
    n_checks++; if ({log_adr[base+2], log_dat[base+2]} !== {5'h18, 32'h0}) begin n_fail++; $display("[TB] FAIL wberr_clr_ss: got %h %h expected 18 00000000", log_adr[base+2], log_dat[base+2]); end
  endtask

  task automatic test_bad_access();
    cb = cyc_cnt;
    apb_xfer(1'b0, 32'h3000_0000, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er, wt, to);
    n_checks++; if ({to, er, wt} !== {2'b01, 32'd1}) begin n_fail++; $display("[TB] FAIL flash_write: got to=%b err=%b waits=%0d expected 0 1 1", to, er, wt); end
    apb_xfer(1'b0, 32'h2000_0000, 1'b0, 32'h0, 4'hF, rd, er, wt, to);
    n_checks++; if ({to, er, wt} !== {2'b01, 32'd1}) begin n_fail++; $display("[TB] FAIL unmapped: got to=%b err=%b waits=%0d expected 0 1 1", to, er, wt); end
    apb_xfer(1'b1, 32'h1000_2000, 1'b0, 32'h0, 4'hF, rd, er, wt, to);
    n_checks++; if ({to, er, wt} !== {2'b01, 32'd1}) begin n_fail++; $display("[TB] FAIL past_reg_end: got to=%b err=%b waits=%0d expected 0 1 1", to, er, wt); end
    n_checks++; if (cyc_cnt !== cb) begin n_fail++; $display("[TB] FAIL bad_no_wb: got %0d cyc cycles expected 0", cyc_cnt - cb); end
  endtask

  task automatic test_reset_mid();
    logic found;
    stuck = 1'b1;
    found = 1'b0;
    @(posedge clock); #1;
    use_b = 1'b0; paddr = 32'h3000_0200; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge clock); #1;
    penable = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (wb_stb_a && !wb_we_a && wb_adr_a == 5'h10) begin found = 1'b1; break; end
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_reach_poll: got %b expected 1", found); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if ({wb_cyc_a, wb_stb_a, busy_a, pready_a, pslverr_a, prdata_a} !== 37'h0) begin n_fail++; $display("[TB] FAIL mid_reset_out: got %h expected 0", {wb_cyc_a, wb_stb_a, busy_a, pready_a, pslverr_a, prdata_a}); end
    psel = 1'b0; penable = 1'b0; stuck = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_rx = 32'hA1B2_C3D4;
    apb_xfer(1'b0, 32'h3000_0100, 1'b0, 32'h0, 4'hF, rd, er, wt, to);
    n_checks++; if ({to, er, rd} !== {2'b00, 32'hD4C3_B2A1}) begin n_fail++; $display("[TB] FAIL mid_after_read: got to=%b err=%b data=%h expected 0 0 d4c3b2a1", to, er, rd); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_reg_access();
    test_flash_read();
    test_short_read();
    test_timeout();
    test_wb_error();
    test_bad_access();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
